// File: rtl/axi_dual_channel_bridge.sv
// Cache-to-AXI3 master bridge: independent read and write engines, single-beat or full-line INCR bursts.
// Latency: request accept -> ar/awvalid 1 cycle; last R beat -> rd_done 1 cycle; B handshake -> wr_done 1 cycle.
// Backpressure: one request per engine in flight; rd_req_ready also drops while a writeback to the same line is pending.
module axi_dual_channel_bridge #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 8,
    parameter int ID_W   = 4,
    parameter int RD_ID  = 0,
    parameter int WR_ID  = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [31:0]             rd_req_addr,
    input  logic                    rd_req_burst,
    input  logic [2:0]              rd_req_size,
    output logic                    rd_done,
    output logic                    rd_err,
    output logic [DATA_W-1:0]       rd_word,
    output logic [BEATS*DATA_W-1:0] rd_block,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [31:0]             wr_req_addr,
    input  logic                    wr_req_burst,
    input  logic [DATA_W/8-1:0]     wr_req_strb,
    input  logic [DATA_W-1:0]       wr_req_word,
    input  logic [BEATS*DATA_W-1:0] wr_req_block,
    output logic                    wr_done,
    output logic                    wr_err,
    output logic [ID_W-1:0]         arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [DATA_W-1:0]       wdata,
    output logic [DATA_W/8-1:0]     wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int          STRB_W     = DATA_W / 8;
    localparam int          BLK_W      = BEATS * DATA_W;
    localparam int          LINE_BYTES = BEATS * STRB_W;
    localparam logic [31:0] LINE_MASK  = ~(32'(LINE_BYTES) - 32'd1);
    localparam logic [31:0] WORD_MASK  = ~(32'(STRB_W) - 32'd1);
    localparam logic [2:0]  FULL_SIZE  = 3'($clog2(STRB_W));
    localparam logic [7:0]  BURST_LEN  = 8'(BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              r_burst;
    logic [7:0]        w_cnt;
    logic [31:0]       w_line;
    logic [BLK_W-1:0]  w_shift;
    logic              hazard;
    logic              unused_inputs;

    // Fixed AXI attributes: INCR, normal access, bufferable/modifiable, unprivileged.
    assign arid    = ID_W'(RD_ID);
    assign awid    = ID_W'(WR_ID);
    assign wid     = ID_W'(WR_ID);
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'b00;
    assign awlock  = 2'b00;
    assign arcache = 4'b0011;
    assign awcache = 4'b0011;
    assign arprot  = 3'b000;
    assign awprot  = 3'b000;
    assign unused_inputs = ^{rid, bid, rresp[0], bresp[0]};

    // Read-after-write guard: never fetch a line whose writeback has not completed.
    assign hazard       = (w_state != W_IDLE) && ((rd_req_addr & LINE_MASK) == w_line);
    assign rd_req_ready = (r_state == R_IDLE) && !hazard;
    assign wr_req_ready = (w_state == W_IDLE);

    // Read engine: issue AR, collect beats into rd_block/rd_word, pulse rd_done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= R_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            arlen    <= '0;
            arsize   <= '0;
            rready   <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
            rd_word  <= '0;
            rd_block <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_burst  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_req_valid && rd_req_ready) begin
                        r_burst  <= rd_req_burst;
                        rd_block <= '0;
                        r_err    <= 1'b0;
                        r_cnt    <= '0;
                        arvalid  <= 1'b1;
                        araddr   <= rd_req_burst ? (rd_req_addr & LINE_MASK) : rd_req_addr;
                        arlen    <= rd_req_burst ? BURST_LEN : 8'd0;
                        arsize   <= rd_req_burst ? FULL_SIZE : rd_req_size;
                        r_state  <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid) begin
                        if (r_burst) begin
                            for (int i = 0; i < BEATS; i++) begin
                                if (r_cnt == 8'(i)) begin
                                    rd_block[i*DATA_W +: DATA_W] <= rdata;
                                end
                            end
                        end else begin
                            rd_word <= rdata;
                        end
                        r_cnt <= r_cnt + 8'd1;
                        r_err <= r_err | rresp[1];
                        // An early rlast ends the burst; untouched slots stay zero.
                        if (rlast || (r_cnt == arlen)) begin
                            rready  <= 1'b0;
                            rd_done <= 1'b1;
                            rd_err  <= r_err | rresp[1];
                            r_state <= R_DONE;
                        end
                    end
                end
                R_DONE: begin
                    rd_done <= 1'b0;
                    rd_err  <= 1'b0;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write engine: issue AW, stream beats from a shift register, wait for B, pulse wr_done.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            awvalid <= 1'b0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
            wvalid  <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
            wlast   <= 1'b0;
            bready  <= 1'b0;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            w_cnt   <= '0;
            w_line  <= '0;
            w_shift <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req_valid) begin
                        w_line  <= wr_req_addr & LINE_MASK;
                        w_shift <= wr_req_burst ? wr_req_block : BLK_W'(wr_req_word);
                        wstrb   <= wr_req_burst ? {STRB_W{1'b1}} : wr_req_strb;
                        awaddr  <= wr_req_burst ? (wr_req_addr & LINE_MASK) : (wr_req_addr & WORD_MASK);
                        awlen   <= wr_req_burst ? BURST_LEN : 8'd0;
                        awsize  <= FULL_SIZE;
                        awvalid <= 1'b1;
                        w_state <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= w_shift[DATA_W-1:0];
                        wlast   <= (awlen == 8'd0);
                        w_cnt   <= '0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        if (w_cnt == awlen) begin
                            wvalid  <= 1'b0;
                            wlast   <= 1'b0;
                            bready  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt   <= w_cnt + 8'd1;
                            wdata   <= w_shift[2*DATA_W-1:DATA_W];
                            w_shift <= w_shift >> DATA_W;
                            wlast   <= ((w_cnt + 8'd1) == awlen);
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        wr_err  <= bresp[1];
                        wr_done <= 1'b1;
                        w_state <= W_DONE;
                    end
                end
                W_DONE: begin
                    wr_done <= 1'b0;
                    wr_err  <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_dual_channel_bridge.sv
// Bench for axi_dual_channel_bridge: acts as the AXI slave and the cache client.
// Expected values come from address/burst rules and the stimulus arrays held here.
// Every wait is a bounded loop; a missed bound is reported as a failed check.
module tb_axi_dual_channel_bridge;

    localparam int          DW    = 32;
    localparam int          NB    = 8;
    localparam int          IW    = 4;
    localparam int          SW    = DW / 8;
    localparam logic [31:0] LMASK = ~32'(NB * SW - 1);
    localparam logic [31:0] WMASK = ~32'(SW - 1);

    logic clk, rstn;
    logic rd_req_valid, rd_req_ready, rd_req_burst;
    logic [31:0] rd_req_addr;
    logic [2:0] rd_req_size;
    logic rd_done, rd_err;
    logic [DW-1:0] rd_word;
    logic [NB*DW-1:0] rd_block;
    logic wr_req_valid, wr_req_ready, wr_req_burst;
    logic [31:0] wr_req_addr;
    logic [SW-1:0] wr_req_strb;
    logic [DW-1:0] wr_req_word;
    logic [NB*DW-1:0] wr_req_block;
    logic wr_done, wr_err;
    logic [IW-1:0] arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize, arprot, awprot;
    logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0] arcache, awcache;
    logic arvalid, arready, awvalid, awready;
    logic [DW-1:0] rdata, wdata;
    logic [SW-1:0] wstrb;
    logic rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] rbeat [NB];
    logic [1:0]    rrsp  [NB];
    logic [DW-1:0] wbeat [NB];
    logic          m_rburst, m_wburst;
    logic [31:0]   m_waddr;
    logic [SW-1:0] m_wstrb;

    axi_dual_channel_bridge #(.DATA_W(DW), .BEATS(NB), .ID_W(IW), .RD_ID(0), .WR_ID(1)) dut (
        .clk(clk), .rstn(rstn),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_req_burst(rd_req_burst), .rd_req_size(rd_req_size), .rd_done(rd_done), .rd_err(rd_err),
        .rd_word(rd_word), .rd_block(rd_block),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_burst(wr_req_burst), .wr_req_strb(wr_req_strb), .wr_req_word(wr_req_word),
        .wr_req_block(wr_req_block), .wr_done(wr_done), .wr_err(wr_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a read request and check the AR channel the cycle after acceptance.
    task automatic rd_issue(input logic [31:0] addr, input logic burst, input logic [2:0] size);
        rd_req_addr  = addr;
        rd_req_burst = burst;
        rd_req_size  = size;
        rd_req_valid = 1'b1;
        m_rburst     = burst;
        #1;
        check("rd_req_ready", rd_req_ready, 1'b1);
        tick();
        rd_req_valid = 1'b0;
        check("arvalid_set", arvalid, 1'b1);
        check("araddr", araddr, burst ? (addr & LMASK) : addr);
        check("arlen", arlen, burst ? 8'(NB - 1) : 8'd0);
        check("arsize", arsize, burst ? 3'd2 : size);
    endtask

    task automatic rd_ar(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("arvalid_hold", arvalid, 1'b1);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("arvalid_clr", arvalid, 1'b0);
        check("rready_set", rready, 1'b1);
    endtask

    // Deliver nsend beats (rlast on the final one) and check the completion outputs.
    task automatic rd_beats(input int nsend);
        logic [NB*DW-1:0] exp_blk;
        logic             exp_err;
        exp_blk = '0;
        exp_err = 1'b0;
        for (int k = 0; k < nsend; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                rvalid = 1'b0;
                tick();
            end
            check("rready_beat", rready, 1'b1);
            check("rd_done_early", rd_done, 1'b0);
            rvalid = 1'b1;
            rdata  = rbeat[k];
            rresp  = rrsp[k];
            rlast  = (k == nsend - 1);
            exp_blk[k*DW +: DW] = rbeat[k];
            exp_err = exp_err | rrsp[k][1];
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        check("rd_done", rd_done, 1'b1);
        check("rd_err", rd_err, exp_err);
        check("rready_clr", rready, 1'b0);
        if (m_rburst) begin
            check("rd_block", rd_block, exp_blk);
        end else begin
            check("rd_word", rd_word, rbeat[0]);
            check("rd_block_clear", rd_block, '0);
        end
        tick();
        check("rd_done_pulse", rd_done, 1'b0);
        check("rd_idle_ready", rd_req_ready, 1'b1);
    endtask

    task automatic wr_issue(input logic [31:0] addr, input logic burst, input logic [SW-1:0] strb);
        wr_req_addr  = addr;
        wr_req_burst = burst;
        wr_req_strb  = strb;
        wr_req_word  = wbeat[0];
        for (int k = 0; k < NB; k++) wr_req_block[k*DW +: DW] = wbeat[k];
        wr_req_valid = 1'b1;
        m_wburst = burst;
        m_waddr  = addr;
        m_wstrb  = burst ? {SW{1'b1}} : strb;
        #1;
        check("wr_req_ready", wr_req_ready, 1'b1);
        tick();
        wr_req_valid = 1'b0;
        check("awvalid_set", awvalid, 1'b1);
        check("awaddr", awaddr, burst ? (addr & LMASK) : (addr & WMASK));
        check("awlen", awlen, burst ? 8'(NB - 1) : 8'd0);
        check("awsize", awsize, 3'd2);
        check("wvalid_pre", wvalid, 1'b0);
    endtask

    task automatic wr_aw(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("awvalid_hold", awvalid, 1'b1);
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("awvalid_clr", awvalid, 1'b0);
        check("wvalid_set", wvalid, 1'b1);
    endtask

    // toggle=1: wready alternates 1/0; otherwise random. Data/last/strb checked every cycle.
    task automatic wr_data(input bit toggle);
        int  n, k, guard;
        logic w;
        n = m_wburst ? NB : 1;
        k = 0;
        guard = 0;
        while (k < n && guard < 200) begin
            w = toggle ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
            check("wvalid", wvalid, 1'b1);
            check("wdata", wdata, wbeat[k]);
            check("wlast", wlast, (k == n - 1));
            check("wstrb", wstrb, m_wstrb);
            wready = w;
            tick();
            if (w) k++;
            guard++;
        end
        wready = 1'b0;
        check("wr_beats_sent", k, n);
        check("wvalid_clr", wvalid, 1'b0);
        check("wlast_clr", wlast, 1'b0);
        check("bready_set", bready, 1'b1);
    endtask

    task automatic wr_resp(input int delay, input logic [1:0] resp);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("bready_hold", bready, 1'b1);
            check("wr_done_early", wr_done, 1'b0);
        end
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        check("bready_clr", bready, 1'b0);
        check("wr_done", wr_done, 1'b1);
        check("wr_err", wr_err, resp[1]);
        check("hazard_at_done", rd_req_ready, ((rd_req_addr & LMASK) != (m_waddr & LMASK)));
        tick();
        check("wr_done_pulse", wr_done, 1'b0);
        check("wr_idle_ready", wr_req_ready, 1'b1);
        check("hazard_clear", rd_req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic        b;
        rstn = 1'b0;
        rd_req_valid = 0; rd_req_addr = 0; rd_req_burst = 0; rd_req_size = 0;
        wr_req_valid = 0; wr_req_addr = 0; wr_req_burst = 0; wr_req_strb = 0;
        wr_req_word = 0; wr_req_block = 0;
        arready = 0; awready = 0; wready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        bid = 1; bresp = 0; bvalid = 0;
        m_rburst = 0; m_wburst = 0; m_waddr = 0; m_wstrb = 0;
        repeat (3) tick();

        // Reset state and constant attributes.
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_done", {rd_done, wr_done, rd_err, wr_err}, 4'b0);
        check("rst_rd_word", rd_word, '0);
        check("rst_rd_block", rd_block, '0);
        check("rst_ready", {rd_req_ready, wr_req_ready}, 2'b11);
        check("const_burst", {arburst, awburst}, 4'b0101);
        check("const_lock", {arlock, awlock}, 4'b0);
        check("const_cache", {arcache, awcache}, 8'h33);
        check("const_prot", {arprot, awprot}, 6'b0);
        check("const_ids", {arid, awid, wid}, {4'd0, 4'd1, 4'd1});
        rstn = 1'b1;
        tick();

        // Line burst read with 0xA0..0xA7.
        for (int k = 0; k < NB; k++) begin rbeat[k] = 32'hA0 + k; rrsp[k] = 2'b00; end
        rd_issue(32'h1000_0044, 1'b1, 3'd0);
        rd_ar(1);
        rd_beats(NB);

        // Single-byte uncached read with SLVERR.
        rbeat[0] = $urandom; rrsp[0] = 2'b10;
        rd_issue(32'hBFAF_8001, 1'b0, 3'd0);
        rd_ar(0);
        rd_beats(1);

        // Early rlast after 5 beats: remaining slots stay zero.
        for (int k = 0; k < NB; k++) begin rbeat[k] = $urandom; rrsp[k] = 2'($urandom_range(0, 3)); end
        rd_issue(32'h0000_5A20, 1'b1, 3'd0);
        rd_ar(0);
        rd_beats(5);

        // Line write with wready toggling.
        for (int k = 0; k < NB; k++) wbeat[k] = $urandom;
        wr_issue(32'h0000_2000, 1'b1, 4'h0);
        wr_aw(1);
        wr_data(1'b1);
        wr_resp(2, 2'b00);

        // Single write, misaligned address, error response.
        wbeat[0] = $urandom;
        wr_issue(32'h0000_0013, 1'b0, 4'b1000);
        wr_aw(0);
        wr_data(1'b0);
        wr_resp(0, 2'b10);

        // Read-after-write hazard on the same line; other line proceeds concurrently.
        for (int k = 0; k < NB; k++) wbeat[k] = $urandom;
        wr_issue(32'h0000_3000, 1'b1, 4'h0);
        rd_req_addr = 32'h0000_3010; rd_req_burst = 1'b1; rd_req_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hazard_block", rd_req_ready, 1'b0);
            tick();
            check("hazard_no_ar", arvalid, 1'b0);
        end
        rd_req_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin rbeat[k] = $urandom; rrsp[k] = 2'b00; end
        rd_issue(32'h0000_4000, 1'b1, 3'd0);
        check("ar_aw_overlap", {arvalid, awvalid}, 2'b11);
        rd_ar(0);
        rd_beats(NB);
        rd_req_addr = 32'h0000_3010;
        #1;
        check("hazard_still", rd_req_ready, 1'b0);
        wr_aw(0);
        wr_data(1'b0);
        wr_resp(1, 2'b00);

        // Reset in the middle of a read burst.
        for (int k = 0; k < NB; k++) begin rbeat[k] = $urandom; rrsp[k] = 2'b00; end
        rd_issue(32'h0000_5000, 1'b1, 3'd0);
        rd_ar(0);
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rdata = rbeat[k]; rlast = 1'b0;
            tick();
        end
        rdata = rbeat[3];
        rstn  = 1'b0;
        tick();
        check("rst_mid_rready", rready, 1'b0);
        check("rst_mid_arvalid", arvalid, 1'b0);
        check("rst_mid_done", rd_done, 1'b0);
        check("rst_mid_block", rd_block, '0);
        check("rst_mid_ready", rd_req_ready, 1'b1);
        rstn = 1'b1; rvalid = 1'b0;
        tick();
        check("rst_mid_no_done", rd_done, 1'b0);
        tick();

        // Randomised mix of reads and writes.
        for (int it = 0; it < 8; it++) begin
            a = $urandom;
            b = 1'($urandom_range(0, 1));
            for (int k = 0; k < NB; k++) begin rbeat[k] = $urandom; rrsp[k] = 2'($urandom_range(0, 3)); end
            rd_issue(a, b, 3'($urandom_range(0, 2)));
            rd_ar($urandom_range(0, 2));
            rd_beats(b ? NB : 1);
            a = $urandom;
            b = 1'($urandom_range(0, 1));
            for (int k = 0; k < NB; k++) wbeat[k] = $urandom;
            wr_issue(a, b, 4'($urandom_range(1, 15)));
            wr_aw($urandom_range(0, 2));
            wr_data(1'b0);
            wr_resp($urandom_range(0, 2), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_dual_channel_bridge.md
Name: axi_dual_channel_bridge

Overview:
- Parametrised cache-to-AXI3 master bridge with independent read and write engines running concurrently.
- Each engine issues a single-beat (uncached word) or BEATS-beat INCR burst (cache line), and reports per-request completion and AXI error status.
- Sits between the I/D-cache miss/writeback logic and the SoC AXI interconnect.
- A same-line hazard check blocks a read to a line whose writeback is still in flight.

Parameters:
- DATA_W, 32, AXI data width; fixed beat size is DATA_W/8 bytes.
- BEATS, 8, words per cache line; power of two, 2..16.
- ID_W, 4, AXI ID width.
- RD_ID, 0, arid value.
- WR_ID, 1, awid/wid value.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- rd_req_valid  in  1  read request
- rd_req_ready  out  1  read engine accepts request
- rd_req_addr  in  32  byte address
- rd_req_burst  in  1  1 = line burst, 0 = single beat
- rd_req_size  in  3  arsize for single beat
- rd_done  out  1  one-cycle completion pulse
- rd_err  out  1  any beat had rresp[1]=1; valid with rd_done
- rd_word  out  DATA_W  single-beat data
- rd_block  out  BEATS*DATA_W  line data, beat i at bits [i*DATA_W +: DATA_W]
- wr_req_valid  in  1  write request
- wr_req_ready  out  1  write engine accepts request
- wr_req_addr  in  32  byte address
- wr_req_burst  in  1  1 = line burst
- wr_req_strb  in  DATA_W/8  single-beat strobe
- wr_req_word  in  DATA_W  single-beat data
- wr_req_block  in  BEATS*DATA_W  line data
- wr_done  out  1  pulse
- wr_err  out  1  bresp[1]; valid with wr_done
- ar*/aw*/w*/r*/b*  AXI3 master channels:
  - arid/awid/wid  ID_W
  - araddr/awaddr  32
  - arlen/awlen  8
  - arsize/awsize  3
  - arburst/awburst  2
  - arlock/awlock  2
  - arcache/awcache  4
  - arprot/awprot  3
  - arvalid/arready, awvalid/awready
  - rid  ID_W, rdata  DATA_W, rresp  2, rlast, rvalid, rready
  - wdata  DATA_W, wstrb  DATA_W/8, wlast, wvalid, wready
  - bid  ID_W, bresp  2, bvalid, bready

Behaviour:
- Reset (rstn=0 at posedge): both engines IDLE; all valids, rready, bready, wlast, rd_done, wr_done, rd_err, wr_err = 0; rd_word, rd_block = 0. The interconnect shares rstn, so in-flight transactions are abandoned.
- Constant outputs: burst INCR (2'b01), lock 0, cache 4'b0011, prot 3'b000, arid=RD_ID, awid=wid=WR_ID.
- Address alignment: LINE_BYTES = BEATS*DATA_W/8; line address = addr & ~(LINE_BYTES-1).
- Read engine states: R_IDLE, R_AR, R_DATA, R_DONE.
  - rd_req_ready = (R_IDLE) && !hazard.
  - hazard = write engine not W_IDLE && line(rd_req_addr) == line(latched write addr).
  - Accept on valid&&ready: latch request, clear rd_block, err accumulator, and beat counter; go to R_AR with arvalid=1 on the next cycle.
  - Burst: araddr = line address, arlen = BEATS-1, arsize = log2(DATA_W/8).
  - Single: araddr = rd_req_addr unmodified, arlen = 0, arsize = rd_req_size.
  - R_AR: hold ar* stable until arready; then arvalid=0, rready=1, go to R_DATA.
  - R_DATA: each rvalid beat writes rdata to rd_block slot [cnt] (single beat: to rd_word), cnt++, err |= rresp[1].
  - On beat with rlast=1, or cnt==arlen: rready=0, go to R_DONE. An early rlast leaves remaining slots 0.
  - R_DONE: rd_done=1 and rd_err for exactly one cycle, then R_IDLE.
  - Accept-to-arvalid latency = 1 cycle; last beat to rd_done = 1 cycle.
- Write engine states: W_IDLE, W_AW, W_DATA, W_RESP, W_DONE.
  - wr_req_ready = W_IDLE.
  - Accept: latch address, data, and strb.
  - Burst: awaddr = line address, awlen = BEATS-1, wstrb all ones.
  - Single: awaddr = addr with low log2(DATA_W/8) bits cleared, awlen = 0.
  - awsize = log2(DATA_W/8).
  - W_AW: awvalid until awready; then W_DATA with wvalid=1, wdata = beat 0.
  - W_DATA: on wready advance beat; wdata = next word; wlast=1 exactly on beat index awlen (single: first beat). wvalid/wdata/wlast stay stable while wready=0.
  - After the last handshake: wvalid=0, wlast=0, bready=1, go to W_RESP.
  - W_RESP: on bvalid: bready=0, wr_err latch = bresp[1], go to W_DONE.
  - W_DONE: wr_done pulse for 1 cycle, then W_IDLE.
- Concurrency: both engines operate fully independently; ar and aw may be valid in the same cycle. The hazard applies only in the read-after-write direction.

Test Plan:
- Read burst to 0x1000_0044, BEATS=8, rdata 0xA0..0xA7, rresp=0 -> araddr 0x1000_0040, arlen 7, arsize 2; rd_block word0=0xA0, word7=0xA7; rd_done one cycle after rlast; rd_err=0.
- Single read 0xBFAF_8001, size 0, rresp=2'b10 -> araddr 0xBFAF_8001, arlen 0, arsize 0; rd_word = rdata; rd_err=1.
- Write burst at 0x2000, wready toggled 1/0 every cycle -> 8 beats in order, wlast only on 8th, wdata stable while stalled; wr_done after bvalid.
- Write burst to 0x3000 in flight + read request to 0x3010 -> rd_req_ready=0 until wr_done; read to 0x4000 accepted immediately, arvalid overlapping awvalid.
- Single write addr 0x13, strb 4'b1000 -> awaddr 0x10, awlen 0, wlast=1 on first beat, wr_err mirrors bresp[1].
- rstn asserted mid-read-burst (beat 3) -> next cycle rready=0, arvalid=0, rd_req_ready=1, no rd_done pulse.
